pio_reg_bridge: RTL

PIO_REG_BRIDGE -- requirements
Module: pio_reg_bridge

---
 rtl/pio_reg_bridge.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/pio_reg_bridge.sv
// HPS PIO to fabric register bridge: synchronized software strobe bus,
// eight 32-bit registers, encoder snapshots and a setpoint watchdog.
module pio_reg_bridge #(
  parameter int SYNC_STAGES = 2,
  parameter int WDOG_CYCLES = 50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hps_clk,
  input  logic [2:0]  hps_addr,
  input  logic        hps_read,
  input  logic        hps_write,
  input  logic [31:0] hps_wdata,
  output logic [31:0] hps_rdata,
  input  logic [31:0] enc_left,
  input  logic [31:0] enc_right,
  input  logic [7:0]  status_in,
  output logic [31:0] speed_left_sp,
  output logic [31:0] speed_right_sp,
  output logic [7:0]  ctrl,
  output logic        wdog_trip
);

  localparam logic [31:0] ID_VAL = 32'h5049_4F42;
  localparam int SW = 38;
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WW-1:0] WDOG_MAX = WW'(WDOG_CYCLES);
  localparam logic [2:0] FILL_N = 3'(SYNC_STAGES);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WAIT_LOW
  } state_t;

  state_t state;

  logic [SW-1:0] sync_q [SYNC_STAGES];
  logic [SW-1:0] sync_out;
  logic          s_clk;
  logic          s_rd;
  logic          s_wr;
  logic [2:0]    s_addr;
  logic [31:0]   s_wdata;

  logic [2:0]    fill;
  logic          filled;
  logic          clk_prev;

  logic [31:0]   sp_l;
  logic [31:0]   sp_r;
  logic [31:0]   snap_l;
  logic [31:0]   snap_r;
  logic [15:0]   wr_cnt;
  logic [15:0]   rd_cnt;
  logic          err;
  logic [WW-1:0] wdog_cnt;
  logic [31:0]   rd_val;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {hps_clk, hps_read, hps_write,
                    hps_addr, hps_wdata};
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign s_clk    = sync_out[37];
  assign s_rd     = sync_out[36];
  assign s_wr     = sync_out[35];
  assign s_addr   = sync_out[34:32];
  assign s_wdata  = sync_out[31:0];

  assign filled = (fill == FILL_N);

  assign wdog_trip      = (wdog_cnt == WDOG_MAX);
  assign speed_left_sp  = wdog_trip ? 32'h0 : sp_l;
  assign speed_right_sp = wdog_trip ? 32'h0 : sp_r;

  // Address 4 always re-captures, so its read value is the live count.
  always_comb begin
    rd_val = 32'h0;
    unique case (s_addr)
      3'd0: rd_val = ID_VAL;
      3'd1: rd_val = sp_l;
      3'd2: rd_val = sp_r;
      3'd3: rd_val = {24'h0, ctrl};
      3'd4: rd_val = enc_left;
      3'd5: rd_val = snap_r;
      3'd6: rd_val = {err, wdog_trip, 22'h0, status_in};
      3'd7: rd_val = {wr_cnt, rd_cnt};
      default: rd_val = 32'h0;
    endcase
  end

  // Until the chain refills after reset, treat the strobe as already
  // high so a level held through reset never looks like a fresh edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      fill      <= '0;
      clk_prev  <= 1'b1;
      hps_rdata <= '0;
      sp_l      <= '0;
      sp_r      <= '0;
      ctrl      <= '0;
      snap_l    <= '0;
      snap_r    <= '0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      err       <= 1'b0;
      wdog_cnt  <= '0;
    end else begin
      if (!filled) begin
        fill     <= fill + 3'd1;
        clk_prev <= 1'b1;
      end else begin
        clk_prev <= s_clk;
      end

      if (wdog_cnt != WDOG_MAX)
        wdog_cnt <= wdog_cnt + 1'b1;

      unique case (state)
        IDLE: begin
          if (filled && s_clk && !clk_prev)
            state <= EXEC;
        end
        EXEC: begin
          state <= WAIT_LOW;
          if (s_rd && s_wr) begin
            err <= 1'b1;
          end else if (s_wr) begin
            wr_cnt <= wr_cnt + 16'd1;
            unique case (s_addr)
              3'd1: begin
                sp_l     <= s_wdata;
                wdog_cnt <= '0;
              end
              3'd2: begin
                sp_r     <= s_wdata;
                wdog_cnt <= '0;
              end
              3'd3: ctrl <= s_wdata[7:0];
              default: ;
            endcase
          end else if (s_rd) begin
            rd_cnt    <= rd_cnt + 16'd1;
            hps_rdata <= rd_val;
            if (s_addr == 3'd4) begin
              snap_l <= enc_left;
              snap_r <= enc_right;
            end
            if (s_addr == 3'd6)
              err <= 1'b0;
          end
        end
        WAIT_LOW: begin
          if (!s_clk)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
